event_blinker: RTL and testbench
================================

// Module: event_blinker
// PURPOSE
// - Output-side partner to the push-button debouncer. The debouncer turns a button press into an event pulse; this block turns
//   event pulses back into slow, human-visible output on an LED or beeper.
// - Each accepted event produces one blink: led_out high for ON_TICKS ticks, then low for OFF_TICKS ticks.
// - Events that arrive during a blink are counted and replayed back-to-back. Used for ATM/vending keypress and coin feedback.
// PARAMETERS
// - CLK_HZ     100_000_000  system clock frequency
// - TICK_HZ    4            blink time base; DIV = CLK_HZ/TICK_HZ (integer, >=2)
// - ON_TICKS   2            ticks led_out stays high per blink (>=1)
// - OFF_TICKS  1            ticks of low gap after each blink (>=1)
// - PEND_W     3            pending-counter width; max backlog 2**PEND_W-1
// PORTS
// - clk       in   1       system clock, rising edge
// - rst       in   1       asynchronous, active-high reset
// - pulse_in  in   1       event input (typically the debounce output); synchronous to clk
// - led_out   out  1       blink output, registered
// - busy      out  1       high whenever state != IDLE or pend_cnt != 0
// - pend_cnt  out  PEND_W  events accepted but not yet started
// - overflow  out  1       one-cycle pulse: an event was dropped because the backlog was full
// BEHAVIOUR
// - Reset (async, rst=1): every register clears.
//   - led_out=0, pend_cnt=0, overflow=0, busy=0.
//   - State=IDLE, prescaler=0, tick counter=0, edge register=0.
//   - Assertion mid-blink aborts the blink immediately. Blinking resumes only after new events.
// - Event detect:
//   - ev = pulse_in & ~pulse_q, where pulse_q is pulse_in registered.
//   - A high level held for N cycles counts as exactly one event.
// - Prescaler:
//   - Free-running 0..DIV-1; tick=1 for the single cycle where the count is DIV-1.
//   - Never reset by events, so blink edges are tick-aligned.
// - Backlog counter (pend_cnt):
//   - +1 on ev; -1 on a blink start (take).
//   - ev and take in the same cycle: net 0, event accepted.
//   - ev, pend_cnt at max, no take: count unchanged, overflow=1 on the next cycle.
//   - pend_cnt never wraps.
// - FSM (states IDLE, ON, OFF; tcnt counts ticks inside a phase):
//   - IDLE: on tick with pend_cnt!=0 -> ON. take=1, led_out=1, tcnt=0.
//   - ON: on tick, tcnt++. On the tick where tcnt==ON_TICKS-1 -> OFF, led_out=0, tcnt=0.
//   - OFF: on tick, tcnt++. On the tick where tcnt==OFF_TICKS-1:
//     - if pend_cnt!=0 -> ON, take=1, led_out=1, tcnt=0;
//     - else -> IDLE.
//   - Evaluation uses pend_cnt as registered. An ev in the cycle of a tick is not seen until the next tick.
// - Latency:
//   - pend_cnt reflects ev one clk after the rising pulse_in edge.
//   - led_out rises 1..DIV clks after pend_cnt first becomes nonzero.
//   - Blink high time is exactly ON_TICKS*DIV clks; gap is exactly OFF_TICKS*DIV clks.
// - Widths: tcnt is $clog2(max(ON_TICKS,OFF_TICKS)+1) bits; prescaler is $clog2(DIV) bits. No truncation allowed.
// STRUCTURE
// - Shared package/header event_blinker_pkg:
//   - state encoding localparams ST_IDLE=2'd0, ST_ON=2'd1, ST_OFF=2'd2;
//   - DIV computed function.
// - Sub-module tick_gen (parameter DIV; ports clk, rst, tick).
//   - Same role as the codebase slow clock divider, but it emits an enable, not a derived clock.
//   - Top level: edge detect, backlog counter, FSM, output registers.
// TESTING (CLK_HZ=8, TICK_HZ=2 -> DIV=4, ON_TICKS=2, OFF_TICKS=1, PEND_W=2)
// - Reset mid-run:
//   - assert rst for 3 clks during ON -> led_out=0, pend_cnt=0, busy=0 asynchronously;
//   - no blink afterwards without new pulse_in.
// - Single event:
//   - 1-clk pulse_in -> pend_cnt=1 next clk; led_out high 8 clks at the next tick; low 4 clks;
//   - then IDLE, busy=0.
// - Held input: pulse_in high 20 clks -> exactly one blink, pend_cnt peaks at 1.
// - Backlog: 3 pulses 2 clks apart while idle -> 3 blinks back-to-back (8 high/4 low each); pend_cnt steps 3,2,1,0.
// - Overflow:
//   - 4 pulses during the first blink (pend_cnt already 3) -> the 4th drops;
//   - overflow=1 for 1 clk; pend_cnt stays 3.
// - Simultaneous: pulse edge in the take cycle with pend_cnt=3 -> accepted, pend_cnt stays 3, overflow stays 0.

Source files
------------

// File: rtl/event_blinker_pkg.sv
// rtl/event_blinker_pkg.sv - shared state encoding and sizing helpers for event_blinker
//
// Purpose: state codes for the blink FSM and the constant functions the
//          top level uses to size its prescaler and phase counter.
// Ports:   none (package).

package event_blinker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ON   = 2'd1;
  localparam state_t ST_OFF  = 2'd2;

  // System clocks per blink tick.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler emitting a one-cycle tick enable
//
// Purpose: counts 0..DIV-1 forever and raises tick for the single cycle in
//          which the count sits at DIV-1. Produces an enable, not a clock.
// Ports:
//   clk   in  1  system clock, rising edge
//   rst   in  1  asynchronous, active-high reset (count returns to 0)
//   tick  out 1  high one cycle in every DIV

module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/event_blinker.sv
// rtl/event_blinker.sv - turns event pulses into tick-aligned, human-visible blinks
//
// Purpose: each rising edge of pulse_in is queued in a saturating backlog
//          counter; an FSM replays the backlog as blinks of ON_TICKS ticks
//          high followed by OFF_TICKS ticks low, back-to-back.
// Ports:
//   clk       in  1       system clock, rising edge
//   rst       in  1       asynchronous, active-high reset
//   pulse_in  in  1       event input, synchronous to clk
//   led_out   out 1       blink output, registered
//   busy      out 1       blinking or backlog non-empty
//   pend_cnt  out PEND_W  events accepted but not yet started
//   overflow  out 1       one-cycle pulse when an event is dropped

module event_blinker
  import event_blinker_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 4,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 1,
  parameter int PEND_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int TW  = $clog2(max_int(ON_TICKS, OFF_TICKS) + 1);

  localparam logic [TW-1:0]     ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0]     OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0]     T_ONE    = TW'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] P_ONE    = PEND_W'(1);

  logic          tick;
  logic          pulse_q;
  logic          ev;
  logic          pend_nz;
  logic          take;
  logic          led_d;
  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;

  // The prescaler is never restarted by events, so every blink edge lands on a tick.
  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Rising-edge detect: a level held for many cycles is a single event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_in;
    end
  end

  assign ev      = pulse_in & ~pulse_q;
  assign pend_nz = (pend_cnt != '0);

  // Backlog: an event and a take in the same cycle cancel out, so the event is
  // accepted even when the counter is full. Only an untaken event at full drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= ev & ~take & (pend_cnt == PEND_MAX);
      if (ev && !take && (pend_cnt != PEND_MAX)) begin
        pend_cnt <= pend_cnt + P_ONE;
      end else if (take && !ev) begin
        pend_cnt <= pend_cnt - P_ONE;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // FSM next state: everything advances only on a tick, using pend_cnt as
  // registered, so an event in a tick cycle waits for the following tick.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (pend_nz) begin
            state_d = ST_ON;
            tcnt_d  = '0;
          end
        end
        ST_ON: begin
          if (tcnt_q == ON_LAST) begin
            state_d = ST_OFF;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + T_ONE;
          end
        end
        ST_OFF: begin
          if (tcnt_q == OFF_LAST) begin
            state_d = pend_nz ? ST_ON : ST_IDLE;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + T_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tcnt_d  = '0;
        end
      endcase
    end
  end

  // FSM outputs: take consumes one backlog entry on every blink start.
  always_comb begin
    take  = 1'b0;
    led_d = 1'b0;
    if (tick && pend_nz &&
        ((state_q == ST_IDLE) || ((state_q == ST_OFF) && (tcnt_q == OFF_LAST)))) begin
      take = 1'b1;
    end
    if (state_d == ST_ON) begin
      led_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= 1'b0;
    end else begin
      led_out <= led_d;
    end
  end

  assign busy = (state_q != ST_IDLE) || pend_nz;

endmodule

// File: tb/tb_event_blinker.sv
// tb/tb_event_blinker.sv - randomized bench for event_blinker against a blink-schedule model

module tb_event_blinker;

  localparam int CLK_HZ    = 8;
  localparam int TICK_HZ   = 2;
  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int ON_TICKS  = 2;
  localparam int OFF_TICKS = 1;
  localparam int PEND_W    = 2;
  localparam int PMAX      = (1 << PEND_W) - 1;
  localparam int HIGH_CLKS = ON_TICKS * DIV;
  localparam int BLINK_CLKS = (ON_TICKS + OFF_TICKS) * DIV;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pulse_in = 1'b0;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              overflow;

  event_blinker #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .ON_TICKS  (ON_TICKS),
    .OFF_TICKS (OFF_TICKS),
    .PEND_W    (PEND_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .led_out  (led_out),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a blink is a scheduled window [start, start+BLINK_CLKS) in edge
  // numbers since reset release; a new one may start on any tick edge at or
  // after the previous window closes while events are waiting.
  int m_n, m_pend, m_start, m_free;
  bit m_prev;
  bit e_led, e_busy, e_ovf;

  task automatic model_reset();
    m_n = 0; m_pend = 0; m_start = -1000; m_free = 0; m_prev = 1'b0;
    e_led = 1'b0; e_busy = 1'b0; e_ovf = 1'b0;
  endtask

  function automatic bit take_at_next_edge();
    return ((m_n % DIV) == DIV - 1) && (m_n >= m_free) && (m_pend > 0);
  endfunction

  task automatic model_step();
    bit tk, ev;
    int e;
    e  = m_n;
    tk = take_at_next_edge();
    ev = pulse_in && !m_prev;
    e_ovf = ev && !tk && (m_pend == PMAX);
    if (tk) begin
      m_start = e;
      m_free  = e + BLINK_CLKS;
    end
    m_pend = m_pend + ((ev && !e_ovf) ? 1 : 0) - (tk ? 1 : 0);
    m_prev = pulse_in;
    e_led  = (e >= m_start) && (e < m_start + HIGH_CLKS);
    e_busy = (e < m_free) || (m_pend != 0);
    m_n++;
  endtask

  // Observed statistics per scenario, compared against scenario constants.
  int  obs_rises, obs_run, obs_max_high, obs_pend_peak, obs_ovf_cnt;
  logic last_led = 1'b0;

  task automatic clear_obs();
    obs_rises = 0; obs_run = 0; obs_max_high = 0; obs_pend_peak = 0; obs_ovf_cnt = 0;
  endtask

  task automatic cycle(input logic p);
    pulse_in = p;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("led_out",  int'(led_out),  int'(e_led));
    check("pend_cnt", int'(pend_cnt), m_pend);
    check("busy",     int'(busy),     int'(e_busy));
    check("overflow", int'(overflow), int'(e_ovf));
    if (led_out && !last_led) obs_rises++;
    if (led_out) begin
      obs_run++;
      if (obs_run > obs_max_high) obs_max_high = obs_run;
    end else begin
      obs_run = 0;
    end
    if (int'(pend_cnt) > obs_pend_peak) obs_pend_peak = int'(pend_cnt);
    if (overflow) obs_ovf_cnt++;
    last_led = led_out;
  endtask

  task automatic wait_led(input string tag);
    int k;
    k = 0;
    while (!led_out && k < 40) begin
      cycle(1'b0);
      k++;
    end
    if (!led_out) check(tag, 0, 1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_obs();
    repeat (3) @(negedge clk);
    check("rst_led",  int'(led_out),  0);
    check("rst_pend", int'(pend_cnt), 0);
    check("rst_busy", int'(busy),     0);
    check("rst_ovf",  int'(overflow), 0);
    rst = 1'b0;
    model_reset();

    // Single one-clock event
    clear_obs();
    cycle(1'b1);
    check("single_pend_next", int'(pend_cnt), 1);
    repeat (30) cycle(1'b0);
    check("single_rises", obs_rises, 1);
    check("single_high", obs_max_high, HIGH_CLKS);
    check("single_idle", int'(busy), 0);

    // Held input is one event
    clear_obs();
    repeat (20) cycle(1'b1);
    repeat (40) cycle(1'b0);
    check("held_rises", obs_rises, 1);
    check("held_peak", obs_pend_peak, 1);

    // Backlog of three events replayed back-to-back
    clear_obs();
    cycle(1'b1); cycle(1'b0); cycle(1'b1); cycle(1'b0); cycle(1'b1);
    repeat (60) cycle(1'b0);
    check("backlog_rises", obs_rises, 3);
    check("backlog_high", obs_max_high, HIGH_CLKS);

    // Overflow: four events during a blink, the fourth drops
    clear_obs();
    cycle(1'b1);
    wait_led("ovf_led_timeout");
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1);
      cycle(1'b0);
    end
    check("ovf_count", obs_ovf_cnt, 1);
    check("ovf_peak", obs_pend_peak, PMAX);
    check("ovf_pend", int'(pend_cnt), PMAX);

    // Simultaneous event and take with a full backlog
    begin
      int k;
      k = 0;
      while (!take_at_next_edge() && k < 60) begin
        cycle(1'b0);
        k++;
      end
      check("simul_found", int'(take_at_next_edge()), 1);
      cycle(1'b1);
      check("simul_pend", int'(pend_cnt), PMAX);
      check("simul_ovf", int'(overflow), 0);
      repeat (60) cycle(1'b0);
      check("simul_drain", int'(busy), 0);
    end

    // Reset in the middle of a blink
    cycle(1'b1);
    cycle(1'b0);
    wait_led("rst_led_timeout");
    cycle(1'b0);
    rst = 1'b1;
    #1;
    check("midrst_led",  int'(led_out),  0);
    check("midrst_pend", int'(pend_cnt), 0);
    check("midrst_busy", int'(busy),     0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    last_led = 1'b0;
    clear_obs();
    repeat (40) cycle(1'b0);
    check("midrst_no_blink", obs_rises, 0);

    // Randomized traffic with varying event density
    for (int blk = 0; blk < 8; blk++) begin
      int dens;
      dens = $urandom_range(2, 12);
      for (int i = 0; i < 100; i++) begin
        cycle(($urandom_range(0, dens - 1) == 0) ? 1'b1 : 1'b0);
      end
    end
    repeat (60) cycle(1'b0);
    check("final_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
